fp_mul_controller: RTL and testbench
====================================

// Module: fp_mul_controller
//
// PURPOSE
//   Sequences one FP multiply through a shared multi-cycle mantissa multiplier.
//   - Accepts an operand pair over a valid/ready handshake and classifies both operands.
//   - Special cases resolve locally: NaN, inf*0, inf and zero.
//   - All other pairs start the external multiplier and wait for its done pulse.
//   - Returns a result and a status vector over a valid/ready handshake.
//
// PARAMETERS
//   IS_DOUBLE       0                      1 = binary64, 0 = binary32
//   EXP_WIDTH       IS_DOUBLE ? 11 : 8     exponent width
//   MANT_WIDTH      IS_DOUBLE ? 52 : 23    mantissa width; W = EXP_WIDTH+MANT_WIDTH+1
//   TIMEOUT_CYCLES  64                     WAIT_MUL abort limit; used only with FP_MUL_TIMEOUT_EN
//
// PORTS
//   clk         in   1    single clock, rising edge
//   rst_n       in   1    asynchronous active-low reset
//   in_valid    in   1    operand pair valid
//   in_ready    out  1    block accepts a pair (combinational: state==IDLE)
//   op1, op2    in   W    operands, [sign][exp][mantissa]
//   mul_start   out  1    one-cycle start pulse to multiplier
//   mul_op1/2   out  W    registered operands to multiplier, stable until done
//   mul_done    in   1    multiplier result valid (one-cycle pulse)
//   mul_result  in   W    multiplier result
//   out_valid   out  1    result valid
//   out_ready   in   1    consumer accepts result
//   result      out  W    product
//   status      out  4    [3] result_nan, [2] result_inf, [1] result_zero, [0] invalid_operation
//   busy        out  1    state != IDLE
//
// BEHAVIOUR
//   Reset
//     - state=IDLE. mul_start, out_valid, busy, result, status, mul_op1 and mul_op2 are all 0.
//     - in_ready=1, because state is IDLE.
//   FSM: IDLE -> CLASSIFY -> (HOLD | WAIT_MUL -> HOLD) -> IDLE
//     IDLE      in_valid&&in_ready at edge T: capture op1/op2 into mul_op1/mul_op2; go CLASSIFY.
//     CLASSIFY  (cycle T+1) classify both operands:
//               - exp all ones with mant!=0 is NaN; with mant==0 is inf.
//               - exp all zeros with mant==0 is zero; with mant!=0 is denormal.
//               - anything else is normal.
//               Resolve by priority; the first match wins and goes to HOLD:
//               1. Either operand NaN: result = canonical qNaN {0, all ones, 1, 0...}; status=4'b1000.
//               2. inf*zero: result = canonical qNaN; status=4'b1001.
//               3. Either operand inf: result = {s1^s2, all ones, 0}; status=4'b0100.
//               4. Either operand zero: result = {s1^s2, 0...}; status=4'b0010.
//               Otherwise (normal/denormal only): go WAIT_MUL and register mul_start=1.
//     WAIT_MUL  - mul_start is high only in the first WAIT_MUL cycle.
//               - mul_done is sampled from the cycle after mul_start.
//               - On mul_done: result<=mul_result; status<={nan,inf,zero,0} of mul_result; go HOLD.
//               - mul_done together with mul_start is ignored.
//     HOLD      - out_valid=1; result and status are held stable.
//               - On out_valid&&out_ready: clear out_valid and go IDLE.
//               - The next input is accepted no earlier than the following cycle.
//   Latency
//     - Special case: out_valid in cycle T+2.
//     - Normal: out_valid in the cycle after the mul_done edge.
//   Other rules
//     - mul_done outside WAIT_MUL is ignored.
//     - in_valid outside IDLE is ignored; its data is not captured.
//     - Asserting rst_n low in any state aborts the operation immediately and returns all outputs to reset values.
//     - An in-flight multiplier result arriving after reset is ignored.
//
// CONFIGURATION
//   FP_MUL_TIMEOUT_EN defined
//     - A counter of clog2(TIMEOUT_CYCLES+1) bits clears on entry to WAIT_MUL.
//     - It increments in every WAIT_MUL cycle without mul_done.
//     - When it reaches TIMEOUT_CYCLES: result = canonical qNaN, status=4'b1001, go HOLD.
//     - A late mul_done after the timeout is ignored.
//     - mul_done in the same cycle the count reaches the limit wins over the timeout.
//   FP_MUL_TIMEOUT_EN undefined
//     - No counter is built; WAIT_MUL waits indefinitely.
//     - TIMEOUT_CYCLES is unused.
//
// TESTING (IS_DOUBLE=0)
//   1. 0x7FC00001 * 0x3F800000: result=0x7FC00000, status=1000, out_valid at T+2, mul_start never high.
//   2. 0x7F800000 * 0x00000000: result=0x7FC00000, status=1001; swapped operand order gives the same response.
//   3. 0xFF800000 * 0x40000000: result=0xFF800000, status=0100. 0x80000000 * 0x3F800000: result=0x80000000, status=0010.
//   4. 0x40000000 * 0x40400000, model returns 0x40C00000 five cycles after start:
//      - Exactly one mul_start, with mul_op1=0x40000000 and mul_op2=0x40400000.
//      - result=0x40C00000, status=0000.
//      - out_ready held low 3 cycles: result stable; in_valid is ignored while busy.
//   5. rst_n pulsed low in WAIT_MUL: outputs reset immediately; a subsequent mul_done is ignored.
//      A following special-case op then completes normally.
//   6. With FP_MUL_TIMEOUT_EN and mul_done never asserted: status=1001 and result=0x7FC00000
//      after 64 WAIT_MUL cycles.

Source files
------------

// File: rtl/fp_mul_controller.sv
// Sequences one FP multiply through a shared multi-cycle mantissa multiplier,
// resolving special operands locally. Define FP_MUL_TIMEOUT_EN to abort a stalled multiply.
module fp_mul_controller #(
  parameter int IS_DOUBLE      = 0,
  parameter int EXP_WIDTH      = IS_DOUBLE ? 11 : 8,
  parameter int MANT_WIDTH     = IS_DOUBLE ? 52 : 23,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int W             = EXP_WIDTH + MANT_WIDTH + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  output logic         mul_start,
  output logic [W-1:0] mul_op1,
  output logic [W-1:0] mul_op2,
  input  logic         mul_done,
  input  logic [W-1:0] mul_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   status,
  output logic         busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CLASSIFY = 2'd1;
  localparam logic [1:0] S_WAIT_MUL = 2'd2;
  localparam logic [1:0] S_HOLD     = 2'd3;

  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

  function automatic logic is_nan(input logic [W-1:0] v);
    return (&v[W-2:MANT_WIDTH]) && (|v[MANT_WIDTH-1:0]);
  endfunction

  function automatic logic is_inf(input logic [W-1:0] v);
    return (&v[W-2:MANT_WIDTH]) && !(|v[MANT_WIDTH-1:0]);
  endfunction

  function automatic logic is_zero(input logic [W-1:0] v);
    return !(|v[W-2:0]);
  endfunction

  logic [1:0]   state_q, state_d;
  logic [W-1:0] mul_op1_q, mul_op1_d;
  logic [W-1:0] mul_op2_q, mul_op2_d;
  logic         mul_start_q, mul_start_d;
  logic [W-1:0] result_q, result_d;
  logic [3:0]   status_q, status_d;
  logic         out_valid_q, out_valid_d;

  logic op1_nan, op1_inf, op1_zero;
  logic op2_nan, op2_inf, op2_zero;
  logic prod_sign;
  logic done_ok;

  assign op1_nan   = is_nan(mul_op1_q);
  assign op1_inf   = is_inf(mul_op1_q);
  assign op1_zero  = is_zero(mul_op1_q);
  assign op2_nan   = is_nan(mul_op2_q);
  assign op2_inf   = is_inf(mul_op2_q);
  assign op2_zero  = is_zero(mul_op2_q);
  assign prod_sign = mul_op1_q[W-1] ^ mul_op2_q[W-1];
  // A done pulse coincident with the start pulse belongs to an earlier request.
  assign done_ok   = mul_done && !mul_start_q;

`ifdef FP_MUL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    mul_op1_d   = mul_op1_q;
    mul_op2_d   = mul_op2_q;
    mul_start_d = 1'b0;
    result_d    = result_q;
    status_d    = status_q;
    out_valid_d = out_valid_q;
`ifdef FP_MUL_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mul_op1_d = op1;
          mul_op2_d = op2;
          state_d   = S_CLASSIFY;
        end
      end

      S_CLASSIFY: begin
        state_d     = S_HOLD;
        out_valid_d = 1'b1;
        if (op1_nan || op2_nan) begin
          result_d = QNAN;
          status_d = 4'b1000;
        end else if ((op1_inf && op2_zero) || (op1_zero && op2_inf)) begin
          result_d = QNAN;
          status_d = 4'b1001;
        end else if (op1_inf || op2_inf) begin
          result_d = {prod_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
          status_d = 4'b0100;
        end else if (op1_zero || op2_zero) begin
          result_d = {prod_sign, {(W-1){1'b0}}};
          status_d = 4'b0010;
        end else begin
          state_d     = S_WAIT_MUL;
          out_valid_d = 1'b0;
          mul_start_d = 1'b1;
`ifdef FP_MUL_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end

      S_WAIT_MUL: begin
        if (done_ok) begin
          result_d    = mul_result;
          status_d    = {is_nan(mul_result), is_inf(mul_result), is_zero(mul_result), 1'b0};
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
`ifdef FP_MUL_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_LIMIT) begin
            result_d    = QNAN;
            status_d    = 4'b1001;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
`endif
      end

      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mul_op1_q   <= '0;
      mul_op2_q   <= '0;
      mul_start_q <= 1'b0;
      result_q    <= '0;
      status_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_op1_q   <= mul_op1_d;
      mul_op2_q   <= mul_op2_d;
      mul_start_q <= mul_start_d;
      result_q    <= result_d;
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef FP_MUL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign mul_start = mul_start_q;
  assign mul_op1   = mul_op1_q;
  assign mul_op2   = mul_op2_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign status    = status_q;

endmodule

// File: tb/tb_fp_mul_controller.sv
// Self-checking bench for fp_mul_controller (binary32): directed cases plus
// randomized operand pairs checked against an IEEE-class reference model.
module tb_fp_mul_controller;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        mul_start;
  logic [31:0] mul_op1;
  logic [31:0] mul_op2;
  logic        mul_done = 1'b0;
  logic [31:0] mul_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [3:0]  status;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  fp_mul_controller #(.IS_DOUBLE(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op1        (op1),
    .op2        (op2),
    .mul_start  (mul_start),
    .mul_op1    (mul_op1),
    .mul_op2    (mul_op2),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .status     (status),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // 0 normal, 1 denormal, 2 zero, 3 infinity, 4 NaN
  function automatic int fp_class(input logic [31:0] v);
    int e = int'(v[30:23]);
    int m = int'(v[22:0]);
    if (e == 255) return (m != 0) ? 4 : 3;
    if (e == 0)   return (m != 0) ? 1 : 2;
    return 0;
  endfunction

  function automatic logic [3:0] result_status(input logic [31:0] v);
    int c = fp_class(v);
    return {c == 4, c == 3, c == 2, 1'b0};
  endfunction

  function automatic void ref_special(input logic [31:0] a, input logic [31:0] b,
                                      output bit sp, output logic [31:0] r,
                                      output logic [3:0] st);
    int  ca = fp_class(a);
    int  cb = fp_class(b);
    bit  s  = a[31] ^ b[31];
    sp = 1'b1;
    r  = '0;
    st = '0;
    if (ca == 4 || cb == 4) begin
      r = QNAN; st = 4'b1000;
    end else if ((ca == 3 && cb == 2) || (ca == 2 && cb == 3)) begin
      r = QNAN; st = 4'b1001;
    end else if (ca == 3 || cb == 3) begin
      r = s ? 32'hFF80_0000 : 32'h7F80_0000; st = 4'b0100;
    end else if (ca == 2 || cb == 2) begin
      r = s ? 32'h8000_0000 : 32'h0000_0000; st = 4'b0010;
    end else begin
      sp = 1'b0;
    end
  endfunction

  function automatic logic [31:0] make_op(input int cls);
    logic       s = 1'($urandom_range(0, 1));
    logic [7:0] e;
    logic [22:0] m;
    case (cls)
      1:       begin e = 8'd0;   m = 23'($urandom_range(1, 32'h7F_FFFF)); end
      2:       begin e = 8'd0;   m = '0; end
      3:       begin e = 8'hFF;  m = '0; end
      4:       begin e = 8'hFF;  m = 23'($urandom_range(1, 32'h7F_FFFF)); end
      default: begin e = 8'($urandom_range(1, 254)); m = 23'($urandom); end
    endcase
    return {s, e, m};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ":mul_start"}, 32'(mul_start), 32'd0);
    check({tag, ":out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ":busy"},      32'(busy),      32'd0);
    check({tag, ":in_ready"},  32'(in_ready),  32'd1);
    check({tag, ":result"},    result,         32'd0);
    check({tag, ":status"},    32'(status),    32'd0);
    check({tag, ":mul_op1"},   mul_op1,        32'd0);
    check({tag, ":mul_op2"},   mul_op2,        32'd0);
  endtask

  // One full transaction; lat = cycles from mul_start to mul_done.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] mres, input int hold,
                       input bit early_done);
    bit          sp;
    logic [31:0] er;
    logic [3:0]  es;
    ref_special(a, b, sp, er, es);
    if (!sp) begin
      er = mres;
      es = result_status(mres);
    end
    check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op1 = a; op2 = b;
    @(negedge clk);
    in_valid = 1'b0; op1 = $urandom; op2 = $urandom;
    check({tag, ":busy"},      32'(busy),      32'd1);
    check({tag, ":cls_valid"}, 32'(out_valid), 32'd0);
    check({tag, ":cls_start"}, 32'(mul_start), 32'd0);
    check({tag, ":mul_op1"},   mul_op1,        a);
    check({tag, ":mul_op2"},   mul_op2,        b);
    @(negedge clk);
    if (sp) begin
      check({tag, ":sp_start"}, 32'(mul_start), 32'd0);
      check({tag, ":sp_valid"}, 32'(out_valid), 32'd1);
    end else begin
      check({tag, ":start"},    32'(mul_start), 32'd1);
      check({tag, ":st_valid"}, 32'(out_valid), 32'd0);
      if (early_done) begin
        mul_done = 1'b1; mul_result = ~mres;
      end
      for (int i = 1; i < lat; i++) begin
        @(negedge clk);
        mul_done = 1'b0;
        check({tag, ":wait_start"}, 32'(mul_start), 32'd0);
        check({tag, ":wait_valid"}, 32'(out_valid), 32'd0);
        check({tag, ":wait_op1"},   mul_op1,        a);
      end
      @(negedge clk);
      if (lat == 1) check({tag, ":wait_valid"}, 32'(out_valid), 32'd0);
      mul_done = 1'b1; mul_result = mres;
      @(negedge clk);
      mul_done = 1'b0; mul_result = $urandom;
      check({tag, ":done_valid"}, 32'(out_valid), 32'd1);
    end
    check({tag, ":result"}, result,      er);
    check({tag, ":status"}, 32'(status), 32'(es));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op1 = ~a; op2 = ~b;
      @(negedge clk);
      check({tag, ":hold_valid"},  32'(out_valid), 32'd1);
      check({tag, ":hold_result"}, result,         er);
      check({tag, ":hold_status"}, 32'(status),    32'(es));
      check({tag, ":hold_ready"},  32'(in_ready),  32'd0);
      check({tag, ":hold_op1"},    mul_op1,        a);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ":end_valid"}, 32'(out_valid), 32'd0);
    check({tag, ":end_ready"}, 32'(in_ready),  32'd1);
    check({tag, ":end_busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    bit seen;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Stray done pulse while idle
    mul_done = 1'b1; mul_result = 32'h1234_5678;
    @(negedge clk);
    mul_done = 1'b0;
    check("idle_done:valid", 32'(out_valid), 32'd0);
    check("idle_done:busy",  32'(busy),      32'd0);

    // Directed special cases
    do_op("nan",      32'h7FC0_0001, 32'h3F80_0000, 1, 32'd0, 0, 1'b0);
    do_op("inf0",     32'h7F80_0000, 32'h0000_0000, 1, 32'd0, 1, 1'b0);
    do_op("zeroinf",  32'h0000_0000, 32'h7F80_0000, 1, 32'd0, 0, 1'b0);
    do_op("neginf",   32'hFF80_0000, 32'h4000_0000, 1, 32'd0, 0, 1'b0);
    do_op("negzero",  32'h8000_0000, 32'h3F80_0000, 1, 32'd0, 2, 1'b0);

    // Normal multiply through the external unit, consumer stalls 3 cycles
    do_op("mul2x3",   32'h4000_0000, 32'h4040_0000, 5, 32'h40C0_0000, 3, 1'b0);
    // Done pulse coincident with start is ignored
    do_op("early",    32'h3FC0_0000, 32'h0000_0001, 2, 32'h0000_0000, 0, 1'b1);

    // Reset mid-multiply
    in_valid = 1'b1; op1 = 32'h4000_0000; op2 = 32'h3FC0_0000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rst:start", 32'(mul_start), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    mul_done = 1'b1; mul_result = 32'h4040_0000;
    @(negedge clk);
    mul_done = 1'b0;
    check("rst_late:valid",  32'(out_valid), 32'd0);
    check("rst_late:busy",   32'(busy),      32'd0);
    check("rst_late:result", result,         32'd0);
    do_op("after_rst", 32'h7F80_0000, 32'hBF80_0000, 1, 32'd0, 0, 1'b0);

    // Randomized operand pairs
    for (int k = 0; k < 24; k++) begin
      int ca = $urandom_range(0, 9);
      int cb = $urandom_range(0, 9);
      do_op($sformatf("rnd%0d", k), make_op(ca), make_op(cb),
            $urandom_range(1, 6), make_op($urandom_range(0, 6)),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Multiplier never answers
    in_valid = 1'b1; op1 = 32'h4000_0000; op2 = 32'h4000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("stall:start", 32'(mul_start), 32'd1);
`ifdef FP_MUL_TIMEOUT_EN
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = out_valid;
    end
    check("timeout:cycles", 32'(n),      32'd64);
    check("timeout:result", result,      QNAN);
    check("timeout:status", 32'(status), 32'b1001);
    mul_done = 1'b1; mul_result = 32'h4080_0000;
    @(negedge clk);
    mul_done = 1'b0;
    check("timeout_late:result", result,      QNAN);
    check("timeout_late:status", 32'(status), 32'b1001);
`else
    seen = 1'b0;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      n++;
    end
    check("stall:no_valid", 32'(seen), 32'd0);
    check("stall:busy",     32'(busy), 32'd1);
    mul_done = 1'b1; mul_result = 32'h4080_0000;
    @(negedge clk);
    mul_done = 1'b0;
    check("stall:valid",  32'(out_valid), 32'd1);
    check("stall:result", result,         32'h4080_0000);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall:end_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
